jt12_slot_inj: RTL

JT12_SLOT_INJ -- requirements
Module: jt12_slot_inj

---
 rtl/jt12_slot_inj.sv | 128 ++++++++++++
 1 files changed

// File: rtl/jt12_slot_inj.sv
// jt12_slot_inj: injects CPU writes into a 24-slot recirculating register loop.
// Define JT12_WRQUEUE_EN for a 2-entry write FIFO instead of a single pending entry.
module jt12_slot_inj #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic             wr_req,
    input  logic [2:0]       wr_ch,
    input  logic [1:0]       wr_op,
    input  logic [width-1:0] wr_data,
    output logic             wr_ack,
    output logic             wr_err,
    output logic             busy,
    input  logic             clr,
    input  logic [width-1:0] loop_in,
    output logic [width-1:0] loop_out,
    output logic [4:0]       slot,
    output logic             zero
);
    logic [4:0]       sweep_cnt;
    logic             sweep_active;
    logic             ch_valid;
    logic             accept;
    logic             reject;
    logic             inject;
    logic [4:0]       wr_slot;
    logic             head_vld;
    logic [4:0]       head_slot;
    logic [width-1:0] head_data;

    assign ch_valid     = wr_ch <= 3'd5;
    assign wr_slot      = 5'(wr_op) * 5'd6 + 5'(wr_ch);
    assign sweep_active = sweep_cnt != 5'd0;
    assign accept       = wr_req && !busy && ch_valid;
    assign reject       = wr_req && !ch_valid;
    assign inject       = clk_en && head_vld && !sweep_active && (slot == head_slot);
    assign zero         = slot == 5'd0;

    // A pending write overrides the loop only on its own slot; a sweep blanks everything else.
    always_comb begin
        if (inject)
            loop_out = head_data;
        else if (sweep_active)
            loop_out = '0;
        else
            loop_out = loop_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot      <= 5'd0;
            sweep_cnt <= 5'd0;
            wr_ack    <= 1'b0;
            wr_err    <= 1'b0;
        end else begin
            wr_ack <= inject;
            wr_err <= reject;
            if (clk_en)
                slot <= (slot == 5'd23) ? 5'd0 : slot + 5'd1;
            // A new clear always reloads the full revolution, even mid-sweep.
            if (clr)
                sweep_cnt <= 5'd24;
            else if (clk_en && sweep_active)
                sweep_cnt <= sweep_cnt - 5'd1;
        end
    end

`ifdef JT12_WRQUEUE_EN
    logic [1:0]       q_vld;
    logic [4:0]       q_slot [2];
    logic [width-1:0] q_data [2];
    logic             wr_idx;

    assign head_vld  = q_vld[0];
    assign head_slot = q_slot[0];
    assign head_data = q_data[0];
    assign busy      = q_vld[1];
    // Entries stay packed at index 0; a same-cycle pop frees the head for the new write.
    assign wr_idx    = q_vld[0] && !inject;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_vld     <= 2'b00;
            q_slot[0] <= 5'd0;
            q_slot[1] <= 5'd0;
            q_data[0] <= '0;
            q_data[1] <= '0;
        end else begin
            if (inject) begin
                q_vld     <= {1'b0, q_vld[1]};
                q_slot[0] <= q_slot[1];
                q_data[0] <= q_data[1];
            end
            if (accept) begin
                q_vld[wr_idx]  <= 1'b1;
                q_slot[wr_idx] <= wr_slot;
                q_data[wr_idx] <= wr_data;
            end
        end
    end
`else
    logic             pend_vld;
    logic [4:0]       pend_slot;
    logic [width-1:0] pend_data;

    assign head_vld  = pend_vld;
    assign head_slot = pend_slot;
    assign head_data = pend_data;
    assign busy      = pend_vld;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_vld  <= 1'b0;
            pend_slot <= 5'd0;
            pend_data <= '0;
        end else if (accept) begin
            pend_vld  <= 1'b1;
            pend_slot <= wr_slot;
            pend_data <= wr_data;
        end else if (inject) begin
            pend_vld <= 1'b0;
        end
    end
`endif

endmodule
